tcu_thermal_regulator: RTL

Downstream consumer of the I2C temperature-sensor controller in the temperature control unit. It captures each completed 16-bit P3T1035/P3T2030 reading when the controller's `data_valid` rises, and optionally smooths it with a 4-sample moving average. A hysteresis state machine then drives heater, fan and alarm outputs. A watchdog flags a stale sensor when no reading arrives within a configurable window.

---
 rtl/tcu_thermal_regulator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tcu_thermal_regulator.sv
// tcu_thermal_regulator: captures temperature words from the I2C sensor
// controller, optionally smooths them, and drives heater/fan/alarm via a
// hysteresis FSM. A watchdog forces STALE when readings stop arriving.
// Optional feature macro: TCU_AVG_FILTER_EN (4-sample moving average).
module tcu_thermal_regulator #(
    parameter logic signed [11:0] T_LOW          = 12'sd320,
    parameter logic signed [11:0] T_HIGH         = 12'sd400,
    parameter logic signed [11:0] T_CRIT         = 12'sd960,
    parameter logic signed [11:0] HYST           = 12'sd16,
    parameter int unsigned        TIMEOUT_CYCLES = 1_500_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic        [15:0] sensor_out,
    input  logic               data_valid,
    output logic signed [11:0] temp_avg,
    output logic               temp_valid,
    output logic        [2:0]  state,
    output logic               heater_on,
    output logic               fan_on,
    output logic               alarm,
    output logic               stale
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    // Hysteresis bounds widened by one bit so T +/- HYST cannot wrap
    localparam logic signed [12:0] HEAT_EXIT = $signed({T_LOW[11], T_LOW}) + $signed({HYST[11], HYST});
    localparam logic signed [12:0] COOL_EXIT = $signed({T_HIGH[11], T_HIGH}) - $signed({HYST[11], HYST});
    localparam logic signed [12:0] CRIT_EXIT = $signed({T_CRIT[11], T_CRIT}) - $signed({HYST[11], HYST});

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_NORMAL = 3'd1,
        ST_HEAT   = 3'd2,
        ST_COOL   = 3'd3,
        ST_CRIT   = 3'd4,
        ST_STALE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                dv_q, dv_d;
    logic signed [11:0]  raw_q, raw_d;
    logic signed [11:0]  temp_avg_q, temp_avg_d;
    logic        [1:0]   vld_pipe_q, vld_pipe_d;   // [0]: raw_q fresh, [1]: temp_avg fresh
    logic        [CW-1:0] cnt_q, cnt_d;
    logic                heater_q, heater_d, fan_q, fan_d, alarm_q, alarm_d, stale_q, stale_d;
    logic                smp;
    logic                wd_exp;
    logic signed [12:0]  t13;

`ifdef TCU_AVG_FILTER_EN
    logic signed [11:0]  buf_q [4];
    logic signed [11:0]  buf_d [4];
    logic                pre_q, pre_d;       // next accepted sample must preload
    logic                pre_cap_q, pre_cap_d; // preload decision travelling with raw_q
    logic signed [13:0]  sum;

    function automatic logic signed [13:0] ext14(input logic signed [11:0] v);
        return {{2{v[11]}}, v};
    endfunction
`endif

    assign smp    = data_valid & ~dv_q;
    assign wd_exp = (cnt_q == CNT_MAX) && !smp;
    assign t13    = {temp_avg_q[11], temp_avg_q};

    // Capture, filter, valid pipeline and watchdog counter
    always_comb begin
        dv_d       = data_valid;
        raw_d      = smp ? $signed(sensor_out[15:4]) : raw_q;
        vld_pipe_d = {vld_pipe_q[0], smp};
        temp_avg_d = temp_avg_q;
        cnt_d      = cnt_q;
        if (smp)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
`ifdef TCU_AVG_FILTER_EN
        buf_d     = buf_q;
        pre_d     = pre_q;
        pre_cap_d = pre_cap_q;
        sum       = '0;
        if (smp) begin
            pre_cap_d = pre_q;
            pre_d     = 1'b0;
        end
        if (wd_exp)
            pre_d = 1'b1;
        if (vld_pipe_q[0]) begin
            if (pre_cap_q) begin
                for (int i = 0; i < 4; i++) buf_d[i] = raw_q;
            end else begin
                buf_d[0] = raw_q;
                for (int i = 1; i < 4; i++) buf_d[i] = buf_q[i-1];
            end
            sum = ext14(buf_d[0]) + ext14(buf_d[1]) + ext14(buf_d[2]) + ext14(buf_d[3]);
            // sum[13:2] is sum >>> 2, i.e. floor division by 4
            temp_avg_d = sum[13:2];
        end
`else
        if (vld_pipe_q[0])
            temp_avg_d = raw_q;
`endif
    end

    // Hysteresis FSM and state-decoded flags (flags registered alongside state)
    always_comb begin
        state_d = state_q;
        if (vld_pipe_q[1]) begin
            case (state_q)
                ST_INIT, ST_NORMAL, ST_STALE: begin
                    if (temp_avg_q >= T_CRIT)      state_d = ST_CRIT;
                    else if (temp_avg_q < T_LOW)   state_d = ST_HEAT;
                    else if (temp_avg_q > T_HIGH)  state_d = ST_COOL;
                    else                           state_d = ST_NORMAL;
                end
                ST_HEAT: begin
                    if (temp_avg_q >= T_CRIT)      state_d = ST_CRIT;
                    else if (t13 >= HEAT_EXIT)     state_d = ST_NORMAL;
                end
                ST_COOL: begin
                    if (temp_avg_q >= T_CRIT)      state_d = ST_CRIT;
                    else if (t13 <= COOL_EXIT)     state_d = ST_NORMAL;
                end
                ST_CRIT: begin
                    if (t13 <= CRIT_EXIT)          state_d = ST_COOL;
                end
                default:                           state_d = ST_INIT;
            endcase
        end
        // Expiry is already masked by a same-cycle sample
        if (wd_exp)
            state_d = ST_STALE;
        heater_d = (state_d == ST_HEAT);
        fan_d    = (state_d == ST_COOL) || (state_d == ST_CRIT) || (state_d == ST_STALE);
        alarm_d  = (state_d == ST_CRIT) || (state_d == ST_STALE);
        stale_d  = (state_d == ST_STALE);
    end

    // State registers; dv_q resets high so a held data_valid is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            dv_q       <= 1'b1;
            raw_q      <= '0;
            temp_avg_q <= '0;
            vld_pipe_q <= '0;
            cnt_q      <= '0;
            heater_q   <= 1'b0;
            fan_q      <= 1'b0;
            alarm_q    <= 1'b0;
            stale_q    <= 1'b0;
`ifdef TCU_AVG_FILTER_EN
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
            pre_q      <= 1'b1;
            pre_cap_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dv_q       <= dv_d;
            raw_q      <= raw_d;
            temp_avg_q <= temp_avg_d;
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
            heater_q   <= heater_d;
            fan_q      <= fan_d;
            alarm_q    <= alarm_d;
            stale_q    <= stale_d;
`ifdef TCU_AVG_FILTER_EN
            buf_q      <= buf_d;
            pre_q      <= pre_d;
            pre_cap_q  <= pre_cap_d;
`endif
        end
    end

    assign temp_avg   = temp_avg_q;
    assign temp_valid = vld_pipe_q[1];
    assign state      = state_q;
    assign heater_on  = heater_q;
    assign fan_on     = fan_q;
    assign alarm      = alarm_q;
    assign stale      = stale_q;

endmodule
